// File: rtl/logic16_pkg.sv
// Shared types and the bitwise operation table for the logic16 pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: WIDTH constant, op_t opcode enum, logic16_f result function.
package logic16_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOT_A  = 3'd4,
    OP_PASS_A = 3'd5,
    OP_PASS_B = 3'd6,
    OP_ZERO   = 3'd7
  } op_t;

  function automatic logic [WIDTH-1:0] logic16_f(
    input op_t              op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NAND:   r = ~(a & b);
      OP_NOT_A:  r = ~a;
      OP_PASS_A: r = a;
      OP_PASS_B: r = b;
      OP_ZERO:   r = '0;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic16_stage.sv
// One valid/ready register slice carrying a W-bit payload.
// Latency: 1 cycle from in handshake to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; payload holds while stalled.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream.
module logic16_stage
  import logic16_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // The slice can take a new word when empty or when its word leaves this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      // Valid never depends on payload bits, so X data cannot leak into it.
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/logic16_pipe.sv
// Two-stage pipelined 16-bit bitwise logic unit (8 ops) with zero/negative flags.
// Latency: 2 cycles accept-to-out_valid; 1 result per cycle with out_ready held high.
// Backpressure: out/zr/ng hold while out_valid && !out_ready; S1 buffers one more, in_ready = !s1_valid || s2_adv.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, op;
//        out_valid/out_ready with out, zr, ng; txn_cnt when built with LOGIC16_CNT_EN.
// Macro LOGIC16_CNT_EN: adds txn_cnt, a wrapping count of output handshakes.
module logic16_pipe #(
  parameter int WIDTH = logic16_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef LOGIC16_CNT_EN
  ,
  output logic [15:0]      txn_cnt
`endif
);

  import logic16_pkg::*;

  localparam int S1W = 3 + 2 * WIDTH;
  localparam int S2W = WIDTH + 2;

  logic             s1_valid;
  logic [S1W-1:0]   s1_data;
  logic             s2_in_ready;
  logic [S2W-1:0]   s2_in_data;
  logic [S2W-1:0]   s2_data;

  op_t              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_res;

  // S1: operand register. Its downstream ready is S2's ready, which gives
  // s1_adv = s1_valid && s2_adv and in_ready = !s1_valid || s2_adv.
  logic16_stage #(.W(S1W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({op, a, b}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign s1_op  = op_t'(s1_data[S1W-1 -: 3]);
  assign s1_a   = s1_data[2*WIDTH-1 -: WIDTH];
  assign s1_b   = s1_data[WIDTH-1:0];
  assign s1_res = logic16_f(s1_op, s1_a, s1_b);

  // Flags are derived from the same result word they travel with.
  assign s2_in_data = {s1_res, (s1_res == '0), s1_res[WIDTH-1]};

  // S2: result register driving the outputs.
  logic16_stage #(.W(S2W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out = s2_data[S2W-1 -: WIDTH];
  assign zr  = s2_data[1];
  assign ng  = s2_data[0];

`ifdef LOGIC16_CNT_EN
  // Reset has priority over a same-cycle handshake; the counter wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt <= 16'h0000;
    end else if (out_valid && out_ready) begin
      txn_cnt <= txn_cnt + 16'h0001;
    end
  end
`endif

endmodule
